// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC stream adapter: default block sizes,
// collector state encoding and the counter-width helper.
package ldpc_pkg;

  localparam int K_DEF = 960;
  localparam int N_DEF = 1200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } coll_state_e;

  // Width of a counter able to index every bit position of the larger block.
  function automatic int cnt_width(input int k, input int n);
    int m;
    m = (k > n) ? k : n;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(K_DEF, N_DEF);

endpackage

// File: rtl/ldpc_stream_adapter_bit_fifo.sv
// Synchronous 1-bit FIFO with registered full/empty flags. The head entry
// is visible on dout_o the cycle after it was written (no fall-through).
module bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  // A flush wins over any push; a full FIFO refuses pushes even while popping.
  assign push_ok = push_i & ~full_o & ~clr_i;
  assign pop_ok  = pop_i & ~empty_o & ~clr_i;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since empty_o guards reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ldpc_stream_adapter.sv
// Streaming adapter around the LDPC encoder: frames the serial input into
// K-bit SOP/EOP packets and collects N-bit coded frames into a
// double-buffered codeword register, flagging framing errors.
module ldpc_stream_adapter
  import ldpc_pkg::*;
#(
  parameter int K          = K_DEF,
  parameter int N          = N_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         bit_in,
  input  logic         bit_in_valid,
  output logic         bit_in_ready,
  output logic         enc_in_data,
  output logic         enc_in_valid,
  output logic         enc_in_sop,
  output logic         enc_in_eop,
  input  logic         enc_in_ready,
  input  logic         enc_out_data,
  input  logic         enc_out_valid,
  input  logic         enc_out_sop,
  input  logic         enc_out_eop,
  output logic         enc_out_ready,
  output logic [N-1:0] cw_data,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic         err_len,
  output logic         err_sop,
  output logic [15:0]  blk_cnt
);

  localparam int            CW       = cnt_width(K, N);
  localparam logic [CW-1:0] IN_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(N - 1);

  // ---------------- ingress framing ----------------
  logic          fifo_dout, fifo_full, fifo_empty;
  logic          in_xfer;
  logic [CW-1:0] in_cnt_q, in_cnt_d;

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (abort),
    .push_i  (bit_in_valid),
    .din_i   (bit_in),
    .pop_i   (in_xfer),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_in_ready = ~fifo_full | abort;
  assign enc_in_valid = ~fifo_empty & ~abort;
  assign enc_in_data  = fifo_dout & enc_in_valid;
  assign enc_in_sop   = enc_in_valid & (in_cnt_q == '0);
  assign enc_in_eop   = enc_in_valid & (in_cnt_q == IN_LAST);
  assign in_xfer      = enc_in_valid & enc_in_ready;

  // Position within the K-bit block; advances only on transferred beats.
  always_comb begin
    in_cnt_d = in_cnt_q;
    if (in_xfer) in_cnt_d = (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + CW'(1);
    if (abort)   in_cnt_d = '0;
  end

  // Ingress position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_cnt_q <= '0;
    else        in_cnt_q <= in_cnt_d;
  end

  // ---------------- egress collector ----------------
  coll_state_e   state_q, state_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  cw_data_q, cw_data_d;
  logic          cw_valid_q, cw_valid_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic          err_len_q, err_len_d;
  logic          err_sop_q, err_sop_d;
  logic          out_beat;
  logic          frame_done;

  assign enc_out_ready = (state_q != ST_HOLD) & ~abort;
  assign out_beat      = enc_out_valid & enc_out_ready;

  assign cw_data  = cw_data_q;
  assign cw_valid = cw_valid_q;
  assign blk_cnt  = blk_cnt_q;
  assign err_len  = err_len_q;
  assign err_sop  = err_sop_q;

  // Collector next-state: assemble frames, check framing, hand off to output.
  always_comb begin
    state_d    = state_q;
    out_cnt_d  = out_cnt_q;
    shadow_d   = shadow_q;
    cw_data_d  = cw_data_q;
    cw_valid_d = cw_valid_q & ~cw_ready;
    blk_cnt_d  = blk_cnt_q;
    err_len_d  = 1'b0;
    err_sop_d  = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (out_beat) begin
          if (enc_out_sop) begin
            shadow_d[0] = enc_out_data;
            out_cnt_d   = CW'(1);
            state_d     = ST_COLLECT;
          end else begin
            err_sop_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (out_beat) begin
          if (enc_out_sop) begin
            // Unexpected SOP restarts the frame with this beat as bit 0.
            err_sop_d   = 1'b1;
            shadow_d[0] = enc_out_data;
            out_cnt_d   = CW'(1);
          end else begin
            shadow_d[out_cnt_q] = enc_out_data;
            if ((out_cnt_q == OUT_LAST) && enc_out_eop) begin
              frame_done = 1'b1;
            end else if (enc_out_eop || (out_cnt_q == OUT_LAST)) begin
              err_len_d = 1'b1;
              out_cnt_d = '0;
              state_d   = ST_IDLE;
            end else begin
              out_cnt_d = out_cnt_q + CW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (cw_ready) begin
          cw_data_d  = shadow_q;
          cw_valid_d = 1'b1;
          blk_cnt_d  = blk_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completed frame goes straight out if the output slot frees this cycle.
    if (frame_done) begin
      out_cnt_d = '0;
      if (!cw_valid_q || cw_ready) begin
        cw_data_d  = shadow_d;
        cw_valid_d = 1'b1;
        blk_cnt_d  = blk_cnt_q + 16'd1;
        state_d    = ST_IDLE;
      end else begin
        state_d = ST_HOLD;
      end
    end

    // Flush overrides everything except the delivered-codeword count.
    if (abort) begin
      state_d    = ST_IDLE;
      out_cnt_d  = '0;
      shadow_d   = '0;
      cw_data_d  = '0;
      cw_valid_d = 1'b0;
      err_len_d  = 1'b0;
      err_sop_d  = 1'b0;
      blk_cnt_d  = blk_cnt_q;
    end
  end

  // Collector and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_cnt_q  <= '0;
      shadow_q   <= '0;
      cw_data_q  <= '0;
      cw_valid_q <= 1'b0;
      blk_cnt_q  <= '0;
      err_len_q  <= 1'b0;
      err_sop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      shadow_q   <= shadow_d;
      cw_data_q  <= cw_data_d;
      cw_valid_q <= cw_valid_d;
      blk_cnt_q  <= blk_cnt_d;
      err_len_q  <= err_len_d;
      err_sop_q  <= err_sop_d;
    end
  end

endmodule

// File: doc/ldpc_stream_adapter.md
# ldpc_stream_adapter

Parametrised streaming adapter around the LDPC encoder core. It frames an upstream serial bit stream into K-bit Avalon-ST packets (SOP/EOP) with full ready/valid backpressure. It deserialises the encoder's N-bit coded output into a double-buffered codeword register with a ready/valid handshake, and flags framing errors. It sits between the TX bit source and the modulator/slot mapper in the TX chain.

## Interface
- `K`, 960, information bits per block (≥2)
- `N`, 1200, coded bits per block (≥2)
- `FIFO_DEPTH`, 4, ingress bit FIFO depth (power of 2, ≥2)
- `clk` in 1, clock
- `rst_n` in 1, reset, asynchronous, active-low
- `abort` in 1, synchronous flush: clears FIFO, counters, state; discards partial blocks
- `bit_in` in 1, upstream data bit
- `bit_in_valid` in 1, upstream valid
- `bit_in_ready` out 1, FIFO not full
- `enc_in_data`/`enc_in_valid`/`enc_in_sop`/`enc_in_eop` out 1 each, stream to encoder
- `enc_in_ready` in 1, encoder ready
- `enc_out_data`/`enc_out_valid`/`enc_out_sop`/`enc_out_eop` in 1 each, stream from encoder
- `enc_out_ready` out 1, collector ready
- `cw_data` out N, codeword; bit 0 = first coded bit
- `cw_valid` out 1, codeword available
- `cw_ready` in 1, consumer accepts codeword
- `err_len` out 1, one-cycle pulse: EOP at wrong position or missing EOP
- `err_sop` out 1, one-cycle pulse: SOP mid-frame or data without SOP
- `blk_cnt` out 16, codewords delivered, wraps 0xFFFF→0

## Operation
- Reset/abort values: all outputs 0 except `bit_in_ready`=1 (after reset; during `abort` cycle it is 1 as well); `cw_data`=0; `blk_cnt` cleared by reset only, not by `abort`.
- Ingress: bit accepted when `bit_in_valid && bit_in_ready`, pushed to FIFO. `enc_in_valid` = FIFO non-empty. Beat transfers when `enc_in_valid && enc_in_ready`; `in_cnt` (0..K-1) advances only on transfer, wraps K-1→0. `enc_in_sop` = (in_cnt==0), `enc_in_eop` = (in_cnt==K-1), both qualified by `enc_in_valid`. Gaps in `bit_in_valid` do not reset `in_cnt`; framing persists across gaps.
- Simultaneous push and pop while full: push is refused (ready reflects registered full), pop proceeds.
- Egress collector FSM, beats counted on `enc_out_valid && enc_out_ready`:
  - IDLE: beat with SOP → write bit to shadow[0], out_cnt=1, go COLLECT. Beat without SOP → dropped, `err_sop` pulse.
  - COLLECT: write shadow[out_cnt]. SOP → `err_sop`, restart: bit stored at index 0, out_cnt=1. EOP with out_cnt==N-1 → block complete. EOP with out_cnt≠N-1, or out_cnt==N-1 without EOP → `err_len`, discard, IDLE.
  - Complete: if output register empty, or `cw_valid && cw_ready` this cycle, copy shadow→`cw_data`, set `cw_valid`, go IDLE; else go HOLD.
  - HOLD: `enc_out_ready`=0; on `cw_ready` copy shadow→`cw_data`, keep `cw_valid`=1, go IDLE.
- `enc_out_ready` = 1 in IDLE/COLLECT, 0 in HOLD.
- `cw_valid` clears on `cw_ready` unless reloaded in the same cycle. `blk_cnt` increments on each shadow→output copy.

## Timing
- Ingress latency: bit accepted at cycle t is presentable on `enc_in_data` at t+1 (registered FIFO, no fall-through).
- `cw_valid` rises the cycle after the accepted EOP beat when the output register is free. `err_*` pulses occur the cycle after the offending beat.
- Sustained throughput: 1 bit/cycle both sides; back-to-back codewords are lossless if `cw_ready` returns within N cycles.
- `abort` takes priority over all other events in the same cycle.

## Structure
- Package `ldpc_pkg`: default K/N, collector state enum (IDLE, COLLECT, HOLD), `CNT_W = $clog2(max(K,N))`.
- Sub-module `bit_fifo` (sync, 1-bit, parametric depth, full/empty flags); the remainder is flat.

## Test plan
- K=8, N=10, continuous bits, `enc_in_ready`=1 → SOP on beats 0,8,16; EOP on 7,15,23.
- Toggle `enc_in_ready` 50% with continuous input → `bit_in_ready` drops when 4 bits are queued; no bit lost or reordered.
- Encoder emits 10-bit frame 0x2A5 → `cw_data`=10'h2A5 one cycle after EOP; `blk_cnt`=1.
- Two frames back-to-back with `cw_ready`=0 → second enters HOLD, `enc_out_ready`=0; `cw_ready` pulse → second codeword loaded, `blk_cnt`=2.
- EOP at beat 6 → `err_len` pulse, no `cw_valid`; SOP at beat 4 → `err_sop`, following 10-bit frame delivered correctly.
- `abort` mid-frame on both sides → FIFO empty and `in_cnt`=0; the next bit carries SOP; `blk_cnt` is unchanged.
